// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: single-clock FIFO over a 2^addr_width-entry two-port memory.
// Synchronous write, registered read. Provides occupancy count, full/empty,
// programmable almost-full/almost-empty, a read-valid strobe and
// overflow/underflow pulses. Memory contents survive reset; only the
// control state is cleared.
module sync_fifo_ram #(
  parameter int addr_width = 3,
  parameter int data_width = 8,
  parameter int af_level   = 6,
  parameter int ae_level   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [data_width-1:0] w_data,
  input  logic                  rd_en,
  output logic [data_width-1:0] r_data,
  output logic                  r_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [addr_width:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << addr_width;
  localparam int CW    = addr_width + 1;

  // Thresholds pre-sized to the count width so the flag compares are exact.
  localparam logic [addr_width:0] LP_DEPTH = DEPTH[addr_width:0];
  localparam logic [addr_width:0] LP_AF    = af_level[addr_width:0];
  localparam logic [addr_width:0] LP_AE    = ae_level[addr_width:0];

  logic [data_width-1:0] r_mem [DEPTH];
  logic [addr_width-1:0] r_wr_ptr;
  logic [addr_width-1:0] r_rd_ptr;
  logic [addr_width:0]   r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  // Flags are pure decodes of the registered count.
  assign w_full  = (r_count == LP_DEPTH);
  assign w_empty = (r_count == '0);

  // Acceptance uses pre-edge state. A write into a full FIFO is allowed when
  // a read frees the same slot this cycle; a read of an empty FIFO is never
  // satisfied by a same-cycle write (no fall-through). Reset blocks both.
  assign w_wr_acc = reset_n & wr_en & (~w_full | rd_en);
  assign w_rd_acc = reset_n & rd_en & ~w_empty;

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= LP_AF);
  assign almost_empty = (r_count <= LP_AE);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // Storage array: written on an accepted write, never cleared by reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= w_data;
  end

  // Registered read port: the old word is captured before a same-edge write
  // to the same slot lands, giving read-before-write when full.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_rd_acc;
      if (w_rd_acc) r_data <= r_mem[r_rd_ptr];
    end
  end

  // Pointer management: each pointer wraps naturally at addr_width bits.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + addr_width'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + addr_width'(1);
    end
  end

  // Occupancy: +1 on write only, -1 on read only, unchanged on both/neither.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else begin
      unique case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Error pulses: one cycle per rejected request, re-armed every cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= wr_en & w_full & ~rd_en;
      r_underflow <= rd_en & w_empty;
    end
  end

endmodule

// File: tb/tb_sync_fifo_ram.sv
// Bench for sync_fifo_ram (depth 8, af 6, ae 2): a hand-computed vector table
// for the single-step behaviour, then a streamed sequence with a queue model
// covering pointer wraps and a mid-stream reset.
module tb_sync_fifo_ram;

  logic       clk;
  logic       reset_n;
  logic       wr_en;
  logic [7:0] w_data;
  logic       rd_en;
  logic [7:0] r_data;
  logic       r_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  sync_fifo_ram #(
    .addr_width(3), .data_width(8), .af_level(6), .ae_level(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .w_data(w_data),
    .rd_en(rd_en), .r_data(r_data), .r_valid(r_valid), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    logic [7:0] e_rd;
    logic       e_rv;
    logic [3:0] e_cnt;
    logic       e_ovf;
    logic       e_udf;
  } vec_t;

  vec_t tv[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // stream model state
  logic [7:0] mq[$];
  logic [7:0] m_rd;
  logic       m_rv, m_ovf, m_udf;

  function automatic vec_t mk(logic rst_n, logic wr, logic [7:0] wd, logic rd,
                              logic [7:0] e_rd, logic e_rv, logic [3:0] e_cnt,
                              logic e_ovf, logic e_udf);
    vec_t v;
    v.rst_n = rst_n; v.wr = wr; v.wd = wd; v.rd = rd;
    v.e_rd = e_rd; v.e_rv = e_rv; v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_udf = e_udf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Flags are checked against the definitions applied to the expected count.
  task automatic check_outs(input string tag, input logic [7:0] e_rd, input logic e_rv,
                            input logic [3:0] e_cnt, input logic e_ovf, input logic e_udf);
    chk({tag, ".r_data"},       r_data,       e_rd);
    chk({tag, ".r_valid"},      r_valid,      e_rv);
    chk({tag, ".count"},        count,        e_cnt);
    chk({tag, ".full"},         full,         e_cnt == 4'd8);
    chk({tag, ".empty"},        empty,        e_cnt == 4'd0);
    chk({tag, ".almost_full"},  almost_full,  e_cnt >= 4'd6);
    chk({tag, ".almost_empty"}, almost_empty, e_cnt <= 4'd2);
    chk({tag, ".overflow"},     overflow,     e_ovf);
    chk({tag, ".underflow"},    underflow,    e_udf);
  endtask

  task automatic drive(input logic rst, input logic wr, input logic [7:0] wd, input logic rd);
    @(negedge clk);
    reset_n = rst; wr_en = wr; w_data = wd; rd_en = rd;
    @(posedge clk);
    #1;
  endtask

  // One streamed cycle: model predicts from pre-edge state, then compare.
  task automatic step(input string tag, input logic rst, input logic wr,
                      input logic [7:0] wd, input logic rd);
    logic wacc, racc;
    if (!rst) begin
      mq.delete();
      m_rd = 8'h00; m_rv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      wacc  = wr && (mq.size() < 8 || rd);
      racc  = rd && mq.size() > 0;
      m_ovf = wr && mq.size() == 8 && !rd;
      m_udf = rd && mq.size() == 0;
      m_rv  = racc;
      if (racc) m_rd = mq.pop_front();
      if (wacc) mq.push_back(wd);
    end
    drive(rst, wr, wd, rd);
    check_outs(tag, m_rd, m_rv, 4'(mq.size()), m_ovf, m_udf);
  endtask

  initial begin
    reset_n = 1'b0; wr_en = 1'b0; w_data = 8'h00; rd_en = 1'b0;

    // reset, then idle
    tv.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 4'd0, 0, 0));
    tv.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 4'd0, 0, 0));
    // fill with 0x11..0x18
    for (int i = 0; i < 8; i++)
      tv.push_back(mk(1, 1, 8'(8'h11 + i), 0, 8'h00, 0, 4'(i + 1), 0, 0));
    // write while full: dropped, overflow each cycle
    tv.push_back(mk(1, 1, 8'hAA, 0, 8'h00, 0, 4'd8, 1, 0));
    tv.push_back(mk(1, 1, 8'hAA, 0, 8'h00, 0, 4'd8, 1, 0));
    // simultaneous write+read while full: old 0x11 out, 0x55 in
    tv.push_back(mk(1, 1, 8'h55, 1, 8'h11, 1, 4'd8, 0, 0));
    // drain 0x12..0x18 then 0x55; 0xAA never appears
    for (int j = 0; j < 7; j++)
      tv.push_back(mk(1, 0, 8'h00, 1, 8'(8'h12 + j), 1, 4'(7 - j), 0, 0));
    tv.push_back(mk(1, 0, 8'h00, 1, 8'h55, 1, 4'd0, 0, 0));
    // read while empty: underflow, r_data holds
    tv.push_back(mk(1, 0, 8'h00, 1, 8'h55, 0, 4'd0, 0, 1));
    // write+read while empty: write taken, read rejected
    tv.push_back(mk(1, 1, 8'h3C, 1, 8'h55, 0, 4'd1, 0, 1));
    tv.push_back(mk(1, 0, 8'h00, 1, 8'h3C, 1, 4'd0, 0, 0));
    tv.push_back(mk(1, 0, 8'h00, 0, 8'h3C, 0, 4'd0, 0, 0));

    for (int k = 0; k < tv.size(); k++) begin
      drive(tv[k].rst_n, tv[k].wr, tv[k].wd, tv[k].rd);
      check_outs($sformatf("vec%0d", k), tv[k].e_rd, tv[k].e_rv, tv[k].e_cnt,
                 tv[k].e_ovf, tv[k].e_udf);
    end

    // Streamed section: model starts from the table's final state.
    mq.delete();
    m_rd = 8'h3C;
    // 20 writes with interleaved reads: both pointers wrap twice
    for (int i = 0; i < 20; i++)
      step($sformatf("strm%0d", i), 1, 1, 8'(8'h40 + i), (i != 0) && (i % 4 != 0));
    for (int i = 0; i < 3; i++)
      step($sformatf("drain%0d", i), 1, 0, 8'h00, 1);
    // reset with entries still queued and requests active
    step("rst", 0, 1, 8'hEE, 1);
    for (int i = 0; i < 3; i++)
      step($sformatf("post%0d", i), 1, 0, 8'h00, 0);
    step("post_udf", 1, 0, 8'h00, 1);
    step("post_wr", 1, 1, 8'h99, 0);
    step("post_rd", 1, 0, 8'h00, 1);
    step("post_idle", 1, 0, 8'h00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ram.md
Name: sync_fifo_ram

Overview:
- Parametrised single-clock FIFO built on an internal 2^addr_width-entry two-port memory: synchronous write, registered read.
- Adds what the plain dual-port RAM lacks: pointer management, occupancy count, full/empty and programmable almost-full/almost-empty flags, a read-valid strobe, and overflow/underflow error pulses.
- Used as the standard buffering element between producer and consumer stages in the same clock domain.

Parameters:
- addr_width, 3, pointer width; depth = 2**addr_width entries (legal range 1..12).
- data_width, 8, width of each stored word.
- af_level, 6, almost_full asserts when count >= af_level (legal 1..depth).
- ae_level, 2, almost_empty asserts when count <= ae_level (legal 0..depth-1).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  synchronous reset, active-low.
- wr_en  input  1  write request.
- w_data  input  data_width  write data, sampled with wr_en.
- rd_en  input  1  read request.
- r_data  output  data_width  read data, registered.
- r_valid  output  1  one-cycle strobe: r_data holds a newly popped word.
- full  output  1  count == depth.
- empty  output  1  count == 0.
- almost_full  output  1  count >= af_level.
- almost_empty  output  1  count <= ae_level.
- count  output  addr_width+1  current occupancy, 0..depth.
- overflow  output  1  one-cycle pulse: write rejected because full.
- underflow  output  1  one-cycle pulse: read rejected because empty.

Behaviour:
- Reset (reset_n low at a clk edge): wr_ptr=0, rd_ptr=0, count=0, r_data=0, r_valid=0, overflow=0, underflow=0. Outputs then read empty=1, full=0, almost_empty=1, almost_full=(af_level==0 ? 1 : 0), which resolves to 0 for legal settings. Memory contents are not cleared. Reset overrides any concurrent wr_en/rd_en; a transaction in flight is discarded.
- Acceptance is evaluated on pre-edge state:
  - wr_acc = wr_en & (~full | rd_en)
  - rd_acc = rd_en & ~empty
- Write: on wr_acc, mem[wr_ptr] <= w_data and wr_ptr increments modulo depth (natural wrap of addr_width bits).
- Read: on rd_acc, r_data <= mem[rd_ptr], rd_ptr increments modulo depth, and r_valid=1 in the following cycle.
  - Read latency is 1 clock from the accepted rd_en edge to r_data/r_valid.
  - r_data holds its last value when no read is accepted; r_valid=0 in that case.
- Count update: count <= count + wr_acc - rd_acc.
- Flags: full, empty, almost_full and almost_empty are combinational decodes of the registered count, so they reflect the state after each edge.
- Full with wr_en and rd_en in the same cycle: both accepted. The oldest word is read and the new word is written to the freed slot (wr_ptr == rd_ptr at full; the read returns the old data, i.e. read-before-write). Count stays at depth; no overflow.
- Empty with wr_en and rd_en in the same cycle: write accepted, read rejected, underflow=1 for one cycle, count becomes 1. There is no fall-through bypass.
- Full with wr_en only: write dropped, overflow=1 next cycle, pointers and count unchanged.
- Empty with rd_en only: underflow=1 next cycle, r_data unchanged, r_valid=0.
- overflow and underflow are registered single-cycle pulses and are not sticky; sustained illegal requests produce one pulse per cycle.
- Words are read out in exact write order (strict FIFO) across any number of pointer wraps.

Test Plan (defaults: depth 8, af_level 6, ae_level 2):
1. Reset then idle -> empty=1, full=0, count=0, almost_empty=1, almost_full=0, r_valid=0, r_data=0.
2. Write 0x11..0x18 over 8 cycles, then read 8 -> count climbs to 8; almost_full sets at count 6; full sets at count 8. Reads return 0x11..0x18 in order, each one cycle after rd_en with r_valid=1. Flags end at empty=1.
3. When full, hold wr_en with w_data=0xAA for 2 cycles -> overflow pulses on both cycles, count stays 8, and subsequent reads show 0xAA absent.
4. When full, issue wr_en=1 with 0x55 and rd_en=1 together -> read returns 0x11, count stays 8, no overflow. After reading the next 7 words, 0x55 is returned last.
5. When empty, issue wr_en=1 with 0x3C and rd_en=1 together -> underflow=1, r_valid=0, count=1. The next rd_en returns 0x3C.
6. Stream 20 writes with interleaved reads (pointer wrap twice), then assert reset_n=0 for 1 cycle mid-stream -> data stays in order through the wraps. After reset, count=0, empty=1, and no r_valid is seen for the discarded entries.
